key_event_ctrl: RTL and testbench

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_event_ctrl.sv | 120 ++++++++++++
 tb/tb_key_event_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// Key gesture classifier: turns a debounced key level into short-press,
// long-press and double-click pulses, plus a busy flag while a gesture is open.
module key_event_ctrl #(
   parameter int unsigned LONG_CYCLES   = 100,
   parameter int unsigned DCLICK_CYCLES = 40,
   parameter logic        PRESS_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic short_press,
   output logic long_press,
   output logic double_click,
   output logic busy
);

   localparam logic [27:0] LONG_LAST   = 28'(LONG_CYCLES - 1);
   localparam logic [27:0] DCLICK_LAST = 28'(DCLICK_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      LONG   = 3'd2,
      WAIT2  = 3'd3,
      PRESS2 = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [27:0] cnt_q, cnt_d;
   logic        key_d_q, key_d_d;
   logic        short_q, short_d;
   logic        long_q, long_d;
   logic        dclick_q, dclick_d;
   logic        busy_q, busy_d;
   logic        press_edge, release_edge;

   assign press_edge   = (key_in == PRESS_LEVEL) && (key_d_q != PRESS_LEVEL);
   assign release_edge = (key_in != PRESS_LEVEL) && (key_d_q == PRESS_LEVEL);

   always_comb begin
      key_d_d  = key_in;
      state_d  = state_q;
      cnt_d    = cnt_q;
      short_d  = 1'b0;
      long_d   = 1'b0;
      dclick_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (press_edge) state_d = PRESS1;
         end
         PRESS1: begin
            if (release_edge) begin
               state_d = WAIT2;
               cnt_d   = '0;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 28'd1;
            end
         end
         LONG: begin
            if (release_edge) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         // A second press on the window's last cycle still counts as a double click.
         WAIT2: begin
            if (press_edge) begin
               state_d  = PRESS2;
               dclick_d = 1'b1;
               cnt_d    = '0;
            end else if (cnt_q == DCLICK_LAST) begin
               state_d = IDLE;
               short_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 28'd1;
            end
         end
         PRESS2: begin
            if (release_edge) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // Released level at reset makes a key held through reset look like a fresh press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         key_d_q  <= ~PRESS_LEVEL;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         dclick_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         key_d_q  <= key_d_d;
         short_q  <= short_d;
         long_q   <= long_d;
         dclick_q <= dclick_d;
         busy_q   <= busy_d;
      end
   end

   assign short_press  = short_q;
   assign long_press   = long_q;
   assign double_click = dclick_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed gesture scenarios plus random key
// activity, compared every cycle against a timestamp-based gesture model.
module tb_key_event_ctrl;

   localparam int   LONG = 100;
   localparam int   DCL  = 40;
   localparam logic PL   = 1'b0;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic key_in = ~PL;
   logic short_press, long_press, double_click, busy;

   key_event_ctrl #(
      .LONG_CYCLES  (LONG),
      .DCLICK_CYCLES(DCL),
      .PRESS_LEVEL  (PL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .short_press (short_press),
      .long_press  (long_press),
      .double_click(double_click),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int n        = 0;

   // Gesture model: a gesture is open from its first press until it resolves;
   // times are edge indices of the first press and of its release.
   bit m_active = 0;
   bit m_prev   = 0;
   bit m_second = 0;
   bit m_long   = 0;
   int t_press  = -1;
   int t_rel    = -1;

   int n_short, n_long, n_dc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, n, obs, exp);
      end
   endtask

   task automatic model_step(input bit p, output logic [3:0] e);
      bit pe, re;
      pe = p && !m_prev;
      re = !p && m_prev;
      e  = 4'b0000;
      if (!m_active) begin
         if (pe) begin
            m_active = 1; t_press = n; t_rel = -1; m_second = 0; m_long = 0;
         end
      end else if (m_second || m_long) begin
         if (re) m_active = 0;
      end else if (t_rel < 0) begin
         if (re) t_rel = n;
         else if (n - t_press == LONG) begin
            e[2] = 1'b1; m_long = 1;
         end
      end else begin
         if (pe) begin
            e[1] = 1'b1; m_second = 1;
         end else if (n - t_rel == DCL) begin
            e[3] = 1'b1; m_active = 0;
         end
      end
      e[0]   = m_active;
      m_prev = p;
   endtask

   task automatic tick(input logic k);
      logic [3:0] e;
      key_in = k;
      @(posedge clk);
      n++;
      model_step(k == PL, e);
      #1;
      chk("outputs", {28'd0, short_press, long_press, double_click, busy}, {28'd0, e});
      chk("one_pulse", {31'd0, $onehot0({short_press, long_press, double_click})}, 32'd1);
      n_short += int'(short_press);
      n_long  += int'(long_press);
      n_dc    += int'(double_click);
      @(negedge clk);
   endtask

   task automatic hold(input logic k, input int cyc);
      for (int i = 0; i < cyc; i++) tick(k);
   endtask

   task automatic clr_counts();
      n_short = 0; n_long = 0; n_dc = 0;
   endtask

   task automatic expect_counts(input string tag, input int s, input int l, input int d);
      chk({tag, "_short"}, n_short, s);
      chk({tag, "_long"},  n_long,  l);
      chk({tag, "_dclick"}, n_dc,   d);
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      chk("async_reset", {28'd0, short_press, long_press, double_click, busy}, 32'd0);
      m_active = 0;
      m_prev   = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("in_reset", {28'd0, short_press, long_press, double_click, busy}, 32'd0);
      rst = 1'b1;
   endtask

   initial begin
      clr_counts();
      #2 rst = 1'b0;
      #1;
      chk("reset_state", {28'd0, short_press, long_press, double_click, busy}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Single short click
      clr_counts();
      hold(PL, 20); hold(~PL, 61);
      expect_counts("short_click", 1, 0, 0);

      // Long hold
      clr_counts();
      hold(PL, 150); hold(~PL, 5);
      expect_counts("long_hold", 0, 1, 0);

      // Double click with a long second press
      clr_counts();
      hold(PL, 10); hold(~PL, 15); hold(PL, 200); hold(~PL, 5);
      expect_counts("double_click", 0, 0, 1);

      // Second press on the last window cycle
      clr_counts();
      hold(PL, 10); hold(~PL, 40); hold(PL, 5); hold(~PL, 5);
      expect_counts("window_last", 0, 0, 1);

      // Second press one cycle past the window starts a new gesture
      clr_counts();
      hold(PL, 10); hold(~PL, 41); hold(PL, 5); hold(~PL, 45);
      expect_counts("window_past", 2, 0, 0);

      // Reset while held, key still held afterwards
      clr_counts();
      hold(PL, 50);
      do_reset();
      hold(PL, 110); hold(~PL, 5);
      expect_counts("reset_held", 0, 1, 0);

      // Random gestures
      for (int i = 0; i < 150; i++) begin
         hold(PL, int'($urandom_range(1, 120)));
         if ($urandom_range(0, 19) == 0) do_reset();
         hold(~PL, int'($urandom_range(1, 60)));
      end

      // Random fast toggling
      for (int i = 0; i < 600; i++) tick(logic'($urandom_range(0, 1)));
      hold(~PL, 50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
